io_port_ctrl: RTL and testbench

Memory-mapped I/O front end that sits directly between the external world and the Processor core's `inputPort`, `outputPort` and `interrupt` pins. It buffers incoming words from an external producer in a small FIFO and presents the head word on `inputPort`. It raises and holds `interrupt` until the core acknowledges it. It also captures words the core writes to `outputPort` into a holding register drained by an external valid/ready consumer.

---
 rtl/io_port_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_io_port_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// io_port_ctrl
// Memory-mapped I/O front end between external devices and the processor
// core's inputPort / outputPort / interrupt pins.
//
// Input path : an external producer pushes words into a small FIFO over a
//              valid/ready handshake. The head word is shown on inputPort
//              with no latency. The core pops the head word with in_rd.
// Interrupt  : a three-state FSM (IDLE, REQ, SERVICE) raises a registered
//              interrupt while input data is pending and int_en is high.
//              The request is held until the core acknowledges it.
// Output path: a one-word holding register captures core OUT writes. An
//              external consumer drains it over a valid/ready handshake.
//              A write that arrives while the register is occupied is dropped
//              and recorded in a sticky overrun flag.
//
// Handshake rule (both directions): a word moves on a rising edge where
// valid and ready are both high. ready never depends combinationally on
// valid.
//
// Ports
//   clk, rst          : clock; asynchronous active-low reset
//   ext_in_data/valid : producer word and its valid
//   ext_in_ready      : FIFO not full (count != FIFO_DEPTH)
//   inputPort         : FIFO head word, 0 when empty
//   in_rd             : core consumes the head word
//   in_count          : FIFO occupancy
//   int_en, int_ack   : core interrupt enable and acknowledge
//   interrupt         : registered interrupt request
//   proc_out_data/wr  : core OUT data and one-cycle strobe
//   ext_out_data/valid: held output word and its valid
//   ext_out_ready     : consumer takes the held word
//   out_overrun       : sticky, an OUT write was dropped
//   dbg_int_state     : interrupt FSM state (0 IDLE, 1 REQ, 2 SERVICE)

module io_port_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             ext_in_data,
  input  logic                          ext_in_valid,
  output logic                          ext_in_ready,
  output logic [DATA_W-1:0]             inputPort,
  input  logic                          in_rd,
  output logic [$clog2(FIFO_DEPTH):0]   in_count,
  input  logic                          int_en,
  output logic                          interrupt,
  input  logic                          int_ack,
  input  logic [DATA_W-1:0]             proc_out_data,
  input  logic                          proc_out_wr,
  output logic [DATA_W-1:0]             ext_out_data,
  output logic                          ext_out_valid,
  input  logic                          ext_out_ready,
  output logic                          out_overrun,
  output logic [1:0]                    dbg_int_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // Ready is based on the registered count only. A pop in the same cycle
  // does not open a slot until the next cycle.
  assign w_push  = ext_in_valid && !w_full;
  // A pop on an empty FIFO is ignored, even when a push lands in the same
  // cycle, because the core could not have seen that word yet.
  assign w_pop   = in_rd && !w_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is not reset. Words are only visible through the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ext_in_data;
    end
  end

  // FIFO_DEPTH is a power of two, so the pointers wrap through natural
  // overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  assign ext_in_ready = !w_full;
  assign inputPort    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign in_count     = r_count;

  // ---------------------------------------------------------------------------
  // Interrupt FSM
  // ---------------------------------------------------------------------------
  int_state_t r_state;
  int_state_t w_state_nxt;
  logic       r_interrupt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (int_en && !w_empty) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // The acknowledge wins over a simultaneous disable. The core has
        // already taken the interrupt.
        if (int_ack)      w_state_nxt = ST_SERVICE;
        else if (!int_en) w_state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        // Leave on the edge where the FIFO drains. A new request can start
        // from IDLE one cycle later.
        if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_interrupt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= (w_state_nxt == ST_REQ);
    end
  end

  assign interrupt     = r_interrupt;
  assign dbg_int_state = r_state;

  // ---------------------------------------------------------------------------
  // Output holding register
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_overrun;
  logic              w_out_free;

  // The register is free when it is empty or is being drained this cycle.
  // This allows one word per cycle back to back.
  assign w_out_free = !r_out_valid || ext_out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (proc_out_wr && w_out_free) begin
        r_out_data  <= proc_out_data;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && ext_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (proc_out_wr && !w_out_free) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign ext_out_data  = r_out_data;
  assign ext_out_valid = r_out_valid;
  assign out_overrun   = r_overrun;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed stimulus, a queue-based reference model,
// a per-cycle compare on the falling edge, and literal spot checks.

module tb_io_port_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ext_in_data   = '0;
  logic        ext_in_valid  = 1'b0;
  logic        ext_in_ready;
  logic [15:0] inputPort;
  logic        in_rd         = 1'b0;
  logic [2:0]  in_count;
  logic        int_en        = 1'b0;
  logic        interrupt;
  logic        int_ack       = 1'b0;
  logic [15:0] proc_out_data = '0;
  logic        proc_out_wr   = 1'b0;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready = 1'b0;
  logic        out_overrun;
  logic [1:0]  dbg_int_state;

  io_port_ctrl #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .inputPort     (inputPort),
    .in_rd         (in_rd),
    .in_count      (in_count),
    .int_en        (int_en),
    .interrupt     (interrupt),
    .int_ack       (int_ack),
    .proc_out_data (proc_out_data),
    .proc_out_wr   (proc_out_wr),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .out_overrun   (out_overrun),
    .dbg_int_state (dbg_int_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: FIFO as a queue, request phase, output slot
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  int          m_phase = 0;     // 0 idle, 1 requesting, 2 being serviced
  bit          m_int   = 1'b0;
  logic [15:0] m_od    = '0;
  bit          m_ov    = 1'b0;
  bit          m_ovr   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_phase = 0;
      m_int   = 1'b0;
      m_od    = '0;
      m_ov    = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      bit push;
      bit pop;
      int size_now;
      int size_nxt;
      size_now = exp_q.size();
      push     = ext_in_valid && (size_now < 4);
      pop      = in_rd && (size_now > 0);
      size_nxt = size_now + (push ? 1 : 0) - (pop ? 1 : 0);
      case (m_phase)
        0: if (int_en && size_now > 0) m_phase = 1;
        1: if (int_ack) m_phase = 2; else if (!int_en) m_phase = 0;
        2: if (size_nxt == 0) m_phase = 0;
        default: m_phase = 0;
      endcase
      m_int = (m_phase == 1);
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(ext_in_data);
      if (proc_out_wr && m_ov && !ext_out_ready) m_ovr = 1'b1;
      if (proc_out_wr && (!m_ov || ext_out_ready)) begin
        m_od = proc_out_data;
        m_ov = 1'b1;
      end else if (m_ov && ext_out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    chk("ext_in_ready", {31'd0, ext_in_ready}, {31'd0, exp_q.size() != 4});
    chk("in_count", {29'd0, in_count}, exp_q.size());
    chk("inputPort", {16'd0, inputPort}, {16'd0, (exp_q.size() > 0) ? exp_q[0] : 16'h0000});
    chk("interrupt", {31'd0, interrupt}, {31'd0, m_int});
    chk("ext_out_data", {16'd0, ext_out_data}, {16'd0, m_od});
    chk("ext_out_valid", {31'd0, ext_out_valid}, {31'd0, m_ov});
    chk("out_overrun", {31'd0, out_overrun}, {31'd0, m_ovr});
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  logic [15:0] fill_v  [4] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h8001};
  logic [15:0] drain_v [4] = '{16'hABCD, 16'h0F0F, 16'h8001, 16'h5555};

  initial begin
    // Reset
    repeat (2) tick();
    chk("rst_count", {29'd0, in_count}, 0);
    chk("rst_inputPort", {16'd0, inputPort}, 0);
    chk("rst_interrupt", {31'd0, interrupt}, 0);
    chk("rst_out_valid", {31'd0, ext_out_valid}, 0);
    chk("rst_ready", {31'd0, ext_in_ready}, 1);
    rst = 1'b1;
    tick();

    // Fill to full; a fifth word is held off
    for (int i = 0; i < 4; i++) begin
      ext_in_valid = 1'b1;
      ext_in_data  = fill_v[i];
      tick();
    end
    ext_in_data = 16'h5555;
    tick();
    chk("full_count", {29'd0, in_count}, 4);
    chk("full_ready", {31'd0, ext_in_ready}, 0);
    chk("full_head", {16'd0, inputPort}, 32'h1234);

    // Read while full: no write that cycle, then 0x5555 goes in
    in_rd = 1'b1;
    tick();
    in_rd = 1'b0;
    chk("rdfull_count", {29'd0, in_count}, 3);
    chk("rdfull_head", {16'd0, inputPort}, 32'hABCD);
    tick();
    ext_in_valid = 1'b0;
    chk("refill_count", {29'd0, in_count}, 4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", {16'd0, inputPort}, {16'd0, drain_v[i]});
      in_rd = 1'b1;
      tick();
    end
    in_rd = 1'b0;
    chk("empty_head", {16'd0, inputPort}, 0);
    chk("empty_count", {29'd0, in_count}, 0);

    // Interrupt request, acknowledge, service
    int_en       = 1'b1;
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h0042;
    tick();
    ext_in_valid = 1'b0;
    chk("irq_k", {31'd0, interrupt}, 0);
    chk("irq_k_head", {16'd0, inputPort}, 32'h0042);
    tick();
    chk("irq_k1", {31'd0, interrupt}, 1);
    repeat (2) tick();
    chk("irq_held", {31'd0, interrupt}, 1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("irq_ack", {31'd0, interrupt}, 0);
    chk("irq_service_state", {30'd0, dbg_int_state}, 2);
    in_rd = 1'b1;
    tick();
    in_rd = 1'b0;
    chk("irq_idle_state", {30'd0, dbg_int_state}, 0);
    tick();
    chk("irq_idle", {31'd0, interrupt}, 0);

    // Withdraw a request and re-enable
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h0077;
    tick();
    ext_in_valid = 1'b0;
    tick();
    chk("req2", {31'd0, interrupt}, 1);
    int_en = 1'b0;
    tick();
    chk("withdraw", {31'd0, interrupt}, 0);
    chk("withdraw_head", {16'd0, inputPort}, 32'h0077);
    tick();
    int_en = 1'b1;
    tick();
    chk("reassert", {31'd0, interrupt}, 1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    in_rd = 1'b1;
    tick();
    in_rd  = 1'b0;
    int_en = 1'b0;
    chk("svc_done_count", {29'd0, in_count}, 0);

    // Output register: overrun, then drain plus write in one cycle
    proc_out_wr   = 1'b1;
    proc_out_data = 16'h00FF;
    tick();
    proc_out_data = 16'h1111;
    tick();
    proc_out_wr = 1'b0;
    chk("ovr_data", {16'd0, ext_out_data}, 32'h00FF);
    chk("ovr_flag", {31'd0, out_overrun}, 1);
    ext_out_ready = 1'b1;
    proc_out_wr   = 1'b1;
    proc_out_data = 16'h2222;
    tick();
    proc_out_wr   = 1'b0;
    ext_out_ready = 1'b0;
    chk("swap_data", {16'd0, ext_out_data}, 32'h2222);
    chk("swap_valid", {31'd0, ext_out_valid}, 1);
    ext_out_ready = 1'b1;
    tick();
    ext_out_ready = 1'b0;
    chk("drained_valid", {31'd0, ext_out_valid}, 0);
    chk("drained_data", {16'd0, ext_out_data}, 32'h2222);

    // Asynchronous reset mid-stream
    ext_in_valid = 1'b1;
    ext_in_data  = 16'hAAA1;
    tick();
    ext_in_data  = 16'hAAA2;
    tick();
    ext_in_valid  = 1'b0;
    proc_out_wr   = 1'b1;
    proc_out_data = 16'h3333;
    tick();
    proc_out_wr = 1'b0;
    chk("pre_rst_count", {29'd0, in_count}, 2);
    chk("pre_rst_valid", {31'd0, ext_out_valid}, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", {29'd0, in_count}, 0);
    chk("arst_head", {16'd0, inputPort}, 0);
    chk("arst_valid", {31'd0, ext_out_valid}, 0);
    chk("arst_data", {16'd0, ext_out_data}, 0);
    chk("arst_overrun", {31'd0, out_overrun}, 0);
    chk("arst_ready", {31'd0, ext_in_ready}, 1);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_head", {16'd0, inputPort}, 0);
    chk("post_rst_irq", {31'd0, interrupt}, 0);

    // Sustained one word per cycle in both directions
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h00FE;
    tick();
    ext_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_rd         = 1'b1;
      ext_in_data   = 16'h0100 + 16'(i);
      proc_out_wr   = 1'b1;
      proc_out_data = 16'h2200 + 16'(i);
      tick();
    end
    in_rd         = 1'b0;
    ext_in_valid  = 1'b0;
    proc_out_wr   = 1'b0;
    ext_out_ready = 1'b0;
    chk("stream_count", {29'd0, in_count}, 1);
    chk("stream_head", {16'd0, inputPort}, 32'h0107);
    chk("stream_out", {16'd0, ext_out_data}, 32'h2207);
    chk("stream_overrun", {31'd0, out_overrun}, 0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
